alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU instance (module ALU: opcode[3:0], A[7:0], B[7:0] -> result[7:0]) between NUM_REQ requesters.
- Each requester uses a valid/ready handshake. Grants are round-robin.
- Operands are captured, the result is registered, and each response is tagged with the requester ID.
- Sits between GUI/host command sources and the ALU datapath.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, operand/result width; must match ALU.
- OP_W, 4, opcode width; must match ALU.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_opcode  in  NUM_REQ*OP_W  packed opcodes, requester i at slice i.
- req_a  in  NUM_REQ*DATA_W  packed operand A.
- req_b  in  NUM_REQ*DATA_W  packed operand B.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer accept.
- rsp_data  out  DATA_W  ALU result.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester served.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State = IDLE; rr_ptr = 0.
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0.
  - Captured operands = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Combinational grant = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[grant] = 1 only in IDLE; all other bits 0. No valid -> all ready 0.
  - On valid&ready: register opcode/A/B and id -> EXEC.
- EXEC (exactly 1 cycle):
  - ALU inputs are driven from the captured registers.
  - Result registered into rsp_data, id into rsp_id; rsp_valid=1 from the next cycle -> RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id held stable until rsp_ready=1.
  - On handshake: rsp_valid=0, rr_ptr = (id+1) mod NUM_REQ -> IDLE.
  - req_ready = 0 for the whole RESP state.
- Latency: accept edge -> rsp_valid high 2 cycles later. Minimum issue interval is 3 cycles.
- Requester rules:
  - Hold valid and payload stable until ready.
  - Withdrawing valid before ready is a protocol violation; the design does no checking.
  - Only the granted requester's payload is sampled.
- Arithmetic: the result is exactly the ALU output, DATA_W bits, with overflow truncated by the ALU. The arbiter never alters data.
- Simultaneous events:
  - rsp handshake and new req_valid in the same RESP cycle: the new request is not accepted that cycle; it is accepted in the following IDLE cycle.
  - All requesters valid continuously: strict rotation 0,1,..,NUM_REQ-1,0.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, no response is issued, and rr_ptr returns to 0.

Optional Feature:
- Macro: ALU_ARBITER_STATS_EN.
- Defined:
  - Adds output op_count[15:0], reset 0.
  - Increments on each rsp handshake and saturates at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package alu_arb_pkg holds:
  - localparams ALU_DATA_W=8, ALU_OP_W=4.
  - typedef enum logic[1:0] state_t {IDLE, EXEC, RESP}.
  - ALU opcode constants (OP_ADD=4'd0, ...), shared with the bench.
- Sub-module rr_arbiter:
  - Inputs: NUM_REQ-bit request vector and rr_ptr.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- ALU is instantiated once inside alu_arbiter.

Test Plan:
- Single op: reset, req_valid[0]=1, OP_ADD, A=5, B=3 -> req_ready[0]=1 for 1 cycle; rsp_valid 2 cycles later with rsp_data=8, rsp_id=0.
- Contention from reset: both valid; req0 OP_ADD 1+1, req1 OP_ADD 2+2 -> first response id=0 data=2, second id=1 data=4, then rotation continues with 0.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_data and rsp_id stable; req_ready=0 throughout; release -> one handshake only.
- Wrap-around: OP_ADD A=200, B=100 -> rsp_data=44 (8-bit truncation).
- Reset in EXEC: assert rst_n=0 one cycle after accept -> rsp_valid never rises; rr_ptr=0, so with req1 and req0 valid, req0 is granted first.
- Stats (ALU_ARBITER_STATS_EN): preload op_count to 16'hFFFE via force, complete 3 ops -> op_count=16'hFFFF and holds.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the fixed ALU geometry, the arbiter FSM state encoding and the ALU
// opcode constants. The bench imports the opcodes from here so that stimulus
// and datapath agree on the encoding.
package alu_arb_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_OP_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] OP_SHL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] OP_SHR  = 4'd6;
    localparam logic [ALU_OP_W-1:0] OP_PASS = 4'd7;

endpackage

// File: rtl/alu_arbiter_alu.sv
// ALU: the shared 8-bit combinational ALU.
// Ports:
//   opcode [3:0] - operation select (OP_* constants in alu_arb_pkg)
//   A, B   [7:0] - operands
//   result [7:0] - operation result, overflow truncated to 8 bits
// Undefined opcodes produce zero.
module ALU
    import alu_arb_pkg::*;
(
    input  logic [ALU_OP_W-1:0]   opcode,
    input  logic [ALU_DATA_W-1:0] A,
    input  logic [ALU_DATA_W-1:0] B,
    output logic [ALU_DATA_W-1:0] result
);

    // Pure decode of the opcode; shifts use the low three bits of B as amount.
    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = A + B;
            OP_SUB:  result = A - B;
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            OP_SHL:  result = A << B[2:0];
            OP_SHR:  result = A >> B[2:0];
            OP_PASS: result = A;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin request selector.
// Ports:
//   req         [NUM_REQ-1:0] - request vector
//   rr_ptr      [ID_W-1:0]    - highest-priority index for this search
//   grant       [NUM_REQ-1:0] - one-hot grant (all zero when no request)
//   grant_idx   [ID_W-1:0]    - encoded index of the granted requester
//   grant_valid               - at least one request present
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    // One spare bit so rr_ptr + k can be folded back modulo NUM_REQ
    // without wrapping in the narrower index width.
    logic [ID_W:0] pos;
    logic          found;

    // Walk from rr_ptr upward, wrapping, and keep the first request seen.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(NUM_REQ)) begin
                pos = pos - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req[pos[ID_W-1:0]]) begin
                found                 = 1'b1;
                grant[pos[ID_W-1:0]]  = 1'b1;
                grant_idx             = pos[ID_W-1:0];
            end
        end
    end

    assign grant_valid = found;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between NUM_REQ valid/ready requesters.
// A round-robin grant is offered only in IDLE; the granted payload is
// captured, executed for one cycle, and the result is returned on the
// response channel tagged with the requester index.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   req_valid/req_ready    - per-requester command handshake
//   req_opcode/req_a/req_b - packed per-requester payloads, slice i = requester i
//   rsp_valid/rsp_ready    - response handshake
//   rsp_data, rsp_id       - registered ALU result and served requester index
//   op_count [15:0]        - saturating response counter, only present when
//                            ALU_ARBITER_STATS_EN is defined
// DATA_W and OP_W must equal the ALU geometry (8 and 4).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = ALU_DATA_W,
    parameter int OP_W    = ALU_OP_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*OP_W-1:0]     req_opcode,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [15:0]                 op_count
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]     opcode_q, opcode_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_valid;
    logic [DATA_W-1:0]   alu_result;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // The ALU only ever sees captured operands, so requester payloads may
    // change freely once their handshake has completed.
    ALU u_alu (
        .opcode (opcode_q),
        .A      (a_q),
        .B      (b_q),
        .result (alu_result)
    );

    // Next-state and handshake logic. A grant in IDLE is also the accept,
    // because the grant is only offered to a requester that is valid.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        opcode_d   = opcode_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (grant_valid) begin
                    opcode_d = req_opcode[grant_idx*OP_W +: OP_W];
                    a_d      = req_a[grant_idx*DATA_W +: DATA_W];
                    b_d      = req_b[grant_idx*DATA_W +: DATA_W];
                    id_d     = grant_idx;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_result;
                rsp_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                // Priority moves just past the requester that was served.
                if (rsp_ready) begin
                    rr_ptr_d = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            opcode_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            opcode_q   <= opcode_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef ALU_ARBITER_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    // Counts completed responses and sticks at the maximum value.
    always_comb begin
        op_count_d = op_count_q;
        if (state_q == RESP && rsp_ready && op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with two
// requesters. Expected responses are queued as commands are driven and are
// matched by a response monitor in order. Define ALU_ARBITER_STATS_EN to also
// exercise the response counter.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int NUM_REQ = 2;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [7:0]   req_opcode;
    logic [15:0]  req_a;
    logic [15:0]  req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [7:0]   rsp_data;
    logic [0:0]   rsp_id;
`ifdef ALU_ARBITER_STATS_EN
    logic [15:0]  op_count;
`endif

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   waited;

    alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
`ifdef ALU_ARBITER_STATS_EN
        ,
        .op_count   (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference for the ALU opcodes.
    function automatic logic [7:0] aluModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] wide;
        case (op)
            4'd0: begin wide = {1'b0, a} + {1'b0, b}; return wide[7:0]; end
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Raise valid for requester i with a payload; optionally queue its result.
    task automatic applyStimulus(input int i, input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input bit push);
        req_opcode[i*4 +: 4] = op;
        req_a[i*8 +: 8]      = a;
        req_b[i*8 +: 8]      = b;
        req_valid[i]         = 1'b1;
        if (push) sb.push_back('{id: i, data: aluModel(op, a, b)});
    endtask

    // Wait (bounded) for requester i to be offered ready; returns cycles waited.
    task automatic waitGrant(input int i, output int cycles);
        logic [31:0] onehot;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!req_ready[i] && cycles < 20);
        onehot = 32'd1 << i;
        checkOutput($sformatf("grant_req%0d", i), {30'd0, req_ready}, onehot);
    endtask

    task automatic acceptDrop(input int i);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Wait (bounded) until every queued response has been seen.
    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        #1;
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    // Response monitor: each accepted response must match the oldest entry.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            checkOutput("rsp_expected", {31'd0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                checkOutput("rsp_data", {24'd0, rsp_data}, {24'd0, mon_e.data});
                checkOutput("rsp_id", {31'd0, rsp_id}, 32'(mon_e.id));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        req_valid  = '0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
        checkOutput("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single op with latency checks.
        $display("[TB] single op");
        applyStimulus(0, OP_ADD, 8'd5, 8'd3, 1'b1);
        waitGrant(0, waited);
        checkOutput("single_ready_first_cycle", 32'(waited), 32'd1);
        acceptDrop(0);
        @(negedge clk);
        checkOutput("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("exec_req_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        checkOutput("resp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        checkOutput("after_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Contention from reset: strict rotation 0,1,0,1 at the 3-cycle interval.
        $display("[TB] contention");
        doReset();
        applyStimulus(0, OP_ADD, 8'd1, 8'd1, 1'b1);
        applyStimulus(1, OP_ADD, 8'd2, 8'd2, 1'b1);
        for (int n = 0; n < 4; n++) begin
            waitGrant(n % 2, waited);
            if (n > 0) checkOutput("issue_interval", 32'(waited), 32'd3);
            @(posedge clk);
            #1;
            if (n == 0)      applyStimulus(0, OP_SUB, 8'd10, 8'd3, 1'b1);
            else if (n == 1) applyStimulus(1, OP_OR, 8'h50, 8'h05, 1'b1);
            else             req_valid[n % 2] = 1'b0;
        end
        drain();

        // Backpressure with a competing request waiting through RESP.
        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        applyStimulus(1, OP_XOR, 8'hF0, 8'h3C, 1'b1);
        waitGrant(1, waited);
        acceptDrop(1);
        applyStimulus(0, OP_AND, 8'hAA, 8'h0F, 1'b1);
        @(negedge clk);
        checkOutput("bp_exec_req_ready", {30'd0, req_ready}, 32'd0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("bp_rsp_data", {24'd0, rsp_data}, 32'h000000CC);
            checkOutput("bp_rsp_id", {31'd0, rsp_id}, 32'd1);
            checkOutput("bp_req_ready", {30'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        waitGrant(0, waited);
        checkOutput("bp_next_grant_delay", 32'(waited), 32'd2);
        acceptDrop(0);
        drain();

        // 8-bit wrap-around.
        $display("[TB] wrap-around");
        applyStimulus(0, OP_ADD, 8'd200, 8'd100, 1'b1);
        waitGrant(0, waited);
        acceptDrop(0);
        drain();

        // Reset during EXEC: no response, pointer back to requester 0.
        $display("[TB] reset in EXEC");
        applyStimulus(1, OP_ADD, 8'd7, 8'd7, 1'b0);
        waitGrant(1, waited);
        acceptDrop(1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(0, OP_XOR, 8'hFF, 8'h0F, 1'b1);
        applyStimulus(1, OP_SUB, 8'd9, 8'd4, 1'b1);
        waitGrant(0, waited);
        checkOutput("rst_exec_first_grant_wait", 32'(waited), 32'd1);
        acceptDrop(0);
        waitGrant(1, waited);
        acceptDrop(1);
        drain();

`ifdef ALU_ARBITER_STATS_EN
        // Saturating response counter.
        $display("[TB] stats");
        force dut.op_count_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.op_count_q;
        checkOutput("stats_preload", {16'd0, op_count}, 32'h0000FFFE);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(0, OP_ADD, 8'(n), 8'd1, 1'b1);
            waitGrant(0, waited);
            acceptDrop(0);
            drain();
            checkOutput("stats_count", {16'd0, op_count}, 32'h0000FFFF);
        end
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
